// File: rtl/uart_boot_loader.sv
// ----------------------------------------------------------------------------
// uart_boot_loader
//
// Receives a program image over an 8N1 UART and writes it into instruction
// memory. The CPU is held in reset until the image is loaded.
//
// Image format: [N] [N words, 4 bytes each, little-endian] [checksum].
// The checksum is the XOR of N and every data byte.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high reset; its release is synchronized
//   rx         - UART serial input (idle high), asynchronous to clk
//   imem_we    - one-cycle instruction-memory write strobe
//   imem_addr  - word address of the write (held until the next write)
//   imem_wdata - write data (held until the next write)
//   cpu_hold   - high while the processor must stay in reset
//   done       - image loaded and checksum matched
//   error      - load failed; sticky until reset
// ----------------------------------------------------------------------------
module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [15:0]       HALF_M1  = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0]       FULL_M1  = 16'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    // Internal reset: asserts together with the external reset, but releases
    // two clk edges later so nothing advances on the release edge itself.
    logic [1:0] rst_pipe;
    logic       rst;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rst_pipe <= 2'b11;
        else       rst_pipe <= {rst_pipe[0], 1'b0};
    end

    assign rst = rst_pipe[1];

    // rx synchronizer plus one more stage for falling-edge detection.
    // All stages reset to the idle-high line level.
    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ------------------------------------------------------------------
    // Byte receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t   rx_state, rx_next;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  rx_shift;
    logic        tick_half, tick_full;
    logic        byte_valid, frame_err;

    assign tick_half = (bit_cnt == HALF_M1);
    assign tick_full = (bit_cnt == FULL_M1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    // The start bit is re-checked at mid-bit so every later sample lands
    // near the middle of its bit; a line already back high there is a glitch.
    always_comb begin
        rx_next    = rx_state;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) rx_next = RX_START;
            end
            RX_START: begin
                if (tick_half) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (tick_full && bit_idx == 3'd7) rx_next = RX_STOP;
            end
            RX_STOP: begin
                if (tick_full) begin
                    rx_next    = RX_IDLE;
                    byte_valid = rx_sync;
                    frame_err  = !rx_sync;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // Bit-time counter restarts on every state change and after each data
    // sample; data shifts in LSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= 16'd0;
            bit_idx  <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            if (rx_state == RX_IDLE || rx_next != rx_state ||
                (rx_state == RX_DATA && tick_full))
                bit_cnt <= 16'd0;
            else
                bit_cnt <= bit_cnt + 16'd1;

            if (rx_state == RX_START)
                bit_idx <= 3'd0;
            else if (rx_state == RX_DATA && tick_full) begin
                bit_idx  <= bit_idx + 3'd1;
                rx_shift <= {rx_sync, rx_shift[7:1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {WAIT_COUNT, LOAD, CHECK, DONE, ERR} load_state_t;

    load_state_t       state, state_next;
    logic [ADDR_W-1:0] word_count;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_idx;
    logic [7:0]        checksum;
    logic [31:0]       assembler;
    logic [31:0]       assembled;
    logic              last_byte, last_word;

    // The incoming byte lands in the top of the assembler, so after four
    // bytes the first one has been shifted down to bits 7:0.
    assign assembled = {rx_shift, assembler[31:8]};
    assign last_byte = (byte_idx == 2'd3);
    assign last_word = ((word_idx + ADDR_ONE) == word_count);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_COUNT;
        else     state <= state_next;
    end

    // DONE and ERR are terminal; only reset leaves them, so post-load
    // traffic on rx has no effect.
    always_comb begin
        state_next = state;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            WAIT_COUNT: begin
                if (frame_err)
                    state_next = ERR;
                else if (byte_valid)
                    state_next = (rx_shift == 8'd0) ? ERR : LOAD;
            end
            LOAD: begin
                if (frame_err)
                    state_next = ERR;
                else if (byte_valid && last_byte && last_word)
                    state_next = CHECK;
            end
            CHECK: begin
                if (frame_err)
                    state_next = ERR;
                else if (byte_valid)
                    state_next = (rx_shift == checksum) ? DONE : ERR;
            end
            DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            ERR: begin
                error = 1'b1;
            end
            default: state_next = ERR;
        endcase
    end

    // Datapath: count capture, checksum, word assembly and the write port.
    // The write strobe fires the cycle after the fourth byte of a word;
    // address and data are only updated with a write, so they stay stable
    // in between.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            word_count <= '0;
            word_idx   <= '0;
            byte_idx   <= 2'd0;
            checksum   <= 8'd0;
            assembler  <= 32'd0;
        end else begin
            imem_we <= 1'b0;
            if (byte_valid) begin
                if (state == WAIT_COUNT && rx_shift != 8'd0) begin
                    word_count <= ADDR_W'(rx_shift);
                    checksum   <= rx_shift;
                    word_idx   <= '0;
                    byte_idx   <= 2'd0;
                end else if (state == LOAD) begin
                    checksum  <= checksum ^ rx_shift;
                    assembler <= assembled;
                    byte_idx  <= byte_idx + 2'd1;
                    if (last_byte) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= word_idx;
                        imem_wdata <= assembled;
                        word_idx   <= word_idx + ADDR_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// ----------------------------------------------------------------------------
// tb_uart_boot_loader
//
// Drives UART byte streams into uart_boot_loader (CLKS_PER_BIT=16) and checks
// the write port and status outputs against a reference model that derives
// the expected writes and outcome directly from the image byte list.
// Fixed vectors come from a table; random images follow; hand sequences cover
// the glitch and reset-during-load cases.
// ----------------------------------------------------------------------------
module tb_uart_boot_loader;

    localparam int CPB    = 16;
    localparam int ADDR_W = 8;

    logic              clk;
    logic              reset;
    logic              rx;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Every write-strobe cycle seen by the monitor, sampled mid-cycle.
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    int                wr_base;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    // Current image under test and the model's predictions for it.
    logic [7:0] img[$];
    int         bad_idx;
    int         exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic       exp_done;
    logic       exp_err;

    // Fixed vectors share one byte pool. The good-image checksum is the XOR
    // of the count and all data bytes: 02^93^F0^B3^10 = C2.
    logic [7:0] pool [40] = '{
        8'h02, 8'h93, 8'h00, 8'hF0, 8'h00, 8'hB3, 8'h00, 8'h10, 8'h00, 8'hC2,
        8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAB, 8'hCD,
        8'h01, 8'hA5,
        8'h00,
        8'h02, 8'h93, 8'h00, 8'hF0, 8'h00, 8'hB3, 8'h00, 8'h10, 8'h00, 8'hC2,
        8'h11, 8'h22, 8'h33,
        8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09
    };

    typedef struct {
        string name;
        int    start;
        int    len;
        int    bad;
        int    exp_writes;
        logic  exp_done;
        logic  exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected)
            passes++;
        else
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    // Holds reset for a few cycles and checks the reset values while it is
    // still asserted.
    task automatic applyReset(input string name);
        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput({name, ".rst_flags"}, {28'd0, imem_we, cpu_hold, done, error},
                    32'h4);
        checkOutput({name, ".rst_addr"}, 32'(imem_addr), 32'd0);
        checkOutput({name, ".rst_wdata"}, imem_wdata, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic applyStimulus(input string name);
        applyReset(name);
        wr_base = wr_addr_q.size();
        for (int i = 0; i < img.size(); i++)
            sendByte(img[i], (i == bad_idx) ? 1'b0 : 1'b1);
        repeat (20) @(negedge clk);
    endtask

    // Reference model: words are bytes 1..4N grouped by four, low byte first;
    // bytes after a framing error never arrive; the byte after the last word
    // is the checksum.
    task automatic modelImage();
        int valid_len;
        int nw;
        logic [7:0] cks;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        valid_len = (bad_idx >= 0) ? bad_idx : img.size();
        if (valid_len == 0 || img[0] == 8'h00)
            exp_err = 1'b1;
        else begin
            nw = int'(img[0]);
            for (int w = 0; w < nw; w++)
                if (4 * w + 4 < valid_len) begin
                    exp_addr_q.push_back(w);
                    exp_data_q.push_back({img[4*w+4], img[4*w+3], img[4*w+2], img[4*w+1]});
                end
            if (valid_len > 4 * nw + 1) begin
                cks = 8'h00;
                for (int i = 0; i <= 4 * nw; i++) cks ^= img[i];
                if (img[4*nw+1] == cks) exp_done = 1'b1;
                else                    exp_err  = 1'b1;
            end else if (bad_idx >= 0)
                exp_err = 1'b1;
        end
    endtask

    task automatic checkImage(input string name);
        int n_obs;
        modelImage();
        n_obs = wr_addr_q.size() - wr_base;
        checkOutput({name, ".done"}, {31'd0, done}, {31'd0, exp_done});
        checkOutput({name, ".error"}, {31'd0, error}, {31'd0, exp_err});
        checkOutput({name, ".cpu_hold"}, {31'd0, cpu_hold}, {31'd0, !exp_done});
        checkOutput({name, ".n_writes"}, n_obs, exp_addr_q.size());
        for (int i = 0; i < exp_addr_q.size() && i < n_obs; i++) begin
            checkOutput($sformatf("%s.addr%0d", name, i), 32'(wr_addr_q[wr_base+i]),
                        exp_addr_q[i]);
            checkOutput($sformatf("%s.data%0d", name, i), wr_data_q[wr_base+i],
                        exp_data_q[i]);
        end
        if (exp_addr_q.size() > 0) begin
            checkOutput({name, ".hold_addr"}, 32'(imem_addr),
                        exp_addr_q[exp_addr_q.size()-1]);
            checkOutput({name, ".hold_wdata"}, imem_wdata,
                        exp_data_q[exp_data_q.size()-1]);
        end
    endtask

    task automatic loadVec(input int v);
        img.delete();
        for (int i = 0; i < vecs[v].len; i++) img.push_back(pool[vecs[v].start + i]);
        bad_idx = vecs[v].bad;
    endtask

    initial begin
        int n;
        logic [7:0] cks;

        vecs[0] = '{"normal",    0,  10, -1, 2, 1'b1, 1'b0};
        vecs[1] = '{"bad_cks",   10, 8,  -1, 1, 1'b0, 1'b1};
        vecs[2] = '{"framing",   18, 2,  1,  0, 1'b0, 1'b1};
        vecs[3] = '{"zero_cnt",  20, 1,  -1, 0, 1'b0, 1'b1};
        vecs[4] = '{"post_done", 21, 13, -1, 2, 1'b1, 1'b0};
        vecs[5] = '{"one_word",  34, 6,  -1, 1, 1'b1, 1'b0};

        rx    = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            loadVec(v);
            applyStimulus(vecs[v].name);
            checkImage(vecs[v].name);
            checkOutput({vecs[v].name, ".tbl_writes"}, wr_addr_q.size() - wr_base,
                        vecs[v].exp_writes);
            checkOutput({vecs[v].name, ".tbl_status"}, {30'd0, done, error},
                        {30'd0, vecs[v].exp_done, vecs[v].exp_err});
        end

        // Short low pulse must be rejected; the following 00 is then the
        // count byte and must fail the load.
        applyReset("glitch");
        wr_base = wr_addr_q.size();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checkOutput("glitch.status", {29'd0, cpu_hold, done, error}, 32'h4);
        sendByte(8'h00, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("glitch.zero_err", {29'd0, cpu_hold, done, error}, 32'h5);
        checkOutput("glitch.n_writes", wr_addr_q.size() - wr_base, 0);

        // Reset halfway through word 0 and in the middle of a frame; the full
        // image sent afterwards must load from scratch.
        applyReset("mid_load");
        sendByte(8'h02, 1'b1);
        sendByte(8'h93, 1'b1);
        sendByte(8'h00, 1'b1);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        loadVec(0);
        applyStimulus("mid_load");
        checkImage("mid_load");
        checkOutput("mid_load.tbl_writes", wr_addr_q.size() - wr_base, 2);

        // Random images: 1..3 words, sometimes a corrupted checksum,
        // sometimes a framing error on a random byte.
        for (int r = 0; r < 6; r++) begin
            img.delete();
            n = $urandom_range(1, 3);
            img.push_back(8'(n));
            cks = 8'(n);
            for (int i = 0; i < 4 * n; i++) begin
                img.push_back(8'($urandom));
                cks ^= img[img.size()-1];
            end
            if ($urandom_range(0, 3) == 0) cks ^= 8'($urandom_range(1, 255));
            img.push_back(cks);
            if ($urandom_range(0, 1) == 0) img.push_back(8'($urandom));
            bad_idx = ($urandom_range(0, 4) == 0) ? $urandom_range(0, img.size() - 1) : -1;
            applyStimulus($sformatf("rand%0d", r));
            checkImage($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
